fir_filter_seq: RTL and testbench
=================================

# fir_filter_seq

Parametrised, resource-shared symmetric FIR low-pass filter for the heart-rate signal chain. It sits between the SPI sample receiver and the peak/trough detectors. It accepts one unsigned ADC sample per valid/ready handshake and folds symmetric tap pairs through a single multiplier, one pair per cycle. It emits one filtered sample per input, using coefficients loaded at run time through a write port.

## Interface
Parameters:
- DATA_W, 10 — sample width, unsigned in and out
- COEF_W, 16 — coefficient width, signed Q1.(COEF_W-1)
- TAPS, 31 — filter length; must be odd and ≥3. M = (TAPS+1)/2 stored coefficients
- ACC_W, 32 — signed accumulator width

Ports:
- clk  in  1  — single clock; all state updates on posedge
- reset  in  1  — synchronous, active-high
- in_valid  in  1  — input sample offered
- in_data  in  DATA_W  — unsigned sample
- in_ready  out  1  — block can accept a sample; in_ready = (state == IDLE)
- coef_we  in  1  — coefficient write strobe
- coef_addr  in  $clog2(M)  — coefficient index; 0 = outermost pair, M-1 = centre tap
- coef_data  in  COEF_W  — signed coefficient
- out_valid  out  1  — one-cycle pulse; out_data is valid
- out_data  out  DATA_W  — filtered sample
- out_primed  out  1  — delay line holds TAPS real samples

## Operation
- Delay line: v[0..TAPS-1], with v[0] newest. On accept (in_valid && in_ready): v[0] <= in_data and v[k] <= v[k-1].
- States:
  - IDLE → MAC on accept. On that edge, acc <= 0 and idx <= 0.
  - MAC runs for M cycles, then returns to IDLE.
- MAC, idx < M-1: acc += coef[idx] * (v[idx] + v[TAPS-1-idx]).
- MAC, idx = M-1: acc += coef[M-1] * v[M-1].
- Arithmetic:
  - Pair sum is DATA_W+1 bits unsigned, zero-extended to signed.
  - Product is signed, sign-extended to ACC_W. Accumulation wraps modulo 2^ACC_W.
- Scaling: y = acc >>> (COEF_W-1), arithmetic shift (floor).
- Output register:
  - Loaded on the edge that ends the centre-tap cycle.
  - Holds its value until the next result.
  - Saturation or wrap behaviour is set by the macro under Configuration.
- Coefficients:
  - Writes are accepted in every state and take effect at the edge.
  - During MAC, a read in the same cycle as a write to that address sees the old value.
  - coef_addr ≥ M is ignored.
- out_primed:
  - A saturating counter of accepted samples.
  - Goes high in the same cycle as the out_valid of the TAPS-th accepted sample and stays high until reset.
- in_valid while in_ready = 0 is not a transfer. The producer holds data until the handshake completes.

## Timing
- Accept edge = cycle 0. MAC occupies cycles 1..M. out_valid is high in cycle M+1 only.
- in_ready is high again in cycle M+1, so a new sample can be accepted in the same cycle out_valid is high.
- Throughput: one sample per M+1 cycles (17 at defaults). Latency: M+1 cycles.
- Reset values:
  - State IDLE, in_ready 1.
  - out_valid 0, out_data 0, out_primed 0.
  - Delay line, accumulator, all coefficients and the sample counter all 0.
- Reset during MAC aborts the computation. No out_valid is produced for the aborted sample.
- Reset has priority over a simultaneous accept or coefficient write.

## Configuration
- FIR_SAT_EN defined:
  - y < 0 → out_data = 0.
  - y > 2^DATA_W-1 → out_data = 2^DATA_W-1.
  - Otherwise out_data = y.
- FIR_SAT_EN undefined: out_data = y[DATA_W-1:0] (wraps).

## Test plan
All values at default parameters.
- Reset, coefficients left at 0, accept 512 → out_valid exactly 17 cycles after the accept edge, out_data 0, in_ready low for cycles 1..16.
- coef[0] = 0x4000, then impulse 1000 followed by zeros → outputs: 500 for the 1st sample, 0 for samples 2–30, 500 for the 31st, 0 for the 32nd.
- All coefficients 0x0800, DC 100 → output after the 31st sample is 193, and out_primed rises with that out_valid.
- All coefficients 0x0800, DC 1023 → 1023 with FIR_SAT_EN, 958 without.
- coef[0] = 0xC000, impulse 1000 → 0 with FIR_SAT_EN, 524 without.
- in_valid held high with an incrementing counter as data → each value accepted exactly once, one accept per 17 cycles, and out_valid every 17 cycles.
- Reset asserted in cycle 8 of MAC → the next cycle shows in_ready 1, out_valid 0, out_primed 0 and all coefficients 0, with no stray out_valid afterwards.

Source files
------------

// File: rtl/fir_filter_seq.sv
// fir_filter_seq: resource-shared symmetric FIR low-pass filter.
// Accepts one unsigned sample per valid/ready handshake, then folds one
// symmetric tap pair per cycle through a single multiplier (M = (TAPS+1)/2
// cycles) and emits one filtered sample. Coefficients are loaded at run time.
// Build option: define FIR_SAT_EN to clamp the scaled result to
// [0, 2^DATA_W-1]; when it is undefined the result wraps to DATA_W bits.
// ACC_W must exceed COEF_W + DATA_W + 1 so no product bits are lost.
module fir_filter_seq #(
   parameter int DATA_W = 10,
   parameter int COEF_W = 16,
   parameter int TAPS   = 31,
   parameter int ACC_W  = 32
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            in_valid,
   input  logic [DATA_W-1:0]               in_data,
   output logic                            in_ready,
   input  logic                            coef_we,
   input  logic [$clog2((TAPS+1)/2)-1:0]   coef_addr,
   input  logic [COEF_W-1:0]               coef_data,
   output logic                            out_valid,
   output logic [DATA_W-1:0]               out_data,
   output logic                            out_primed
);

   localparam int M   = (TAPS + 1) / 2;
   localparam int AW  = $clog2(M);
   localparam int IW  = $clog2(TAPS);
   localparam int CW  = $clog2(TAPS + 1);
   localparam int SH  = COEF_W - 1;        // Q1.(COEF_W-1) scaling shift
   localparam int TOP = SH + DATA_W;       // first accumulator bit above the output field

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] MAC  = 1'b1;

   logic [0:0]              r_state;
   logic [AW-1:0]           r_idx;
   logic signed [ACC_W-1:0] r_acc;
   logic [DATA_W-1:0]       r_dline [TAPS];
   logic [COEF_W-1:0]       r_coef  [M];
   logic [CW-1:0]           r_cnt;
   logic                    r_primed;
   logic                    r_out_valid;
   logic [DATA_W-1:0]       r_out_data;

   logic                    w_accept;
   logic                    w_is_centre;
   logic [IW-1:0]           w_far_idx;
   logic [DATA_W-1:0]       w_near;
   logic [DATA_W-1:0]       w_far;
   logic [DATA_W:0]         w_pair;
   logic signed [ACC_W-1:0] w_coef_x;
   logic signed [ACC_W-1:0] w_pair_x;
   logic signed [ACC_W-1:0] w_prod;
   logic signed [ACC_W-1:0] w_acc_sum;
   logic [DATA_W-1:0]       w_y_out;

   assign in_ready   = (r_state == IDLE);
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_primed = r_primed;

   assign w_accept    = in_valid && (r_state == IDLE);
   assign w_is_centre = (r_idx == AW'(M - 1));
   assign w_far_idx   = IW'(TAPS - 1) - IW'(r_idx);
   assign w_near      = r_dline[r_idx];
   assign w_far       = r_dline[w_far_idx];

   // The centre tap has no partner; every other index folds its mirror sample.
   assign w_pair = w_is_centre ? {1'b0, w_near} : ({1'b0, w_near} + {1'b0, w_far});

   // Multiply at accumulator width: coefficient sign-extended, pair zero-extended.
   assign w_coef_x  = {{(ACC_W-COEF_W){r_coef[r_idx][COEF_W-1]}}, r_coef[r_idx]};
   assign w_pair_x  = {{(ACC_W-DATA_W-1){1'b0}}, w_pair};
   assign w_prod    = w_coef_x * w_pair_x;
   assign w_acc_sum = r_acc + w_prod;

   // Scale the final sum by an arithmetic right shift and fit it to DATA_W bits.
   always_comb begin
      w_y_out = w_acc_sum[TOP-1:SH];
`ifdef FIR_SAT_EN
      if (w_acc_sum[ACC_W-1]) begin
         w_y_out = '0;
      end else if (|w_acc_sum[ACC_W-2:TOP]) begin
         w_y_out = '1;
      end
`endif
   end

   // Delay line: shift one position per accepted sample, newest at index 0.
   generate
      for (genvar gi = 0; gi < TAPS; gi++) begin : g_dline
         always_ff @(posedge clk) begin
            if (reset) begin
               r_dline[gi] <= '0;
            end else if (w_accept) begin
               if (gi == 0) begin
                  r_dline[gi] <= in_data;
               end else begin
                  r_dline[gi] <= r_dline[(gi > 0) ? gi - 1 : 0];
               end
            end
         end
      end
   endgenerate

   // Coefficient bank: writes land at the edge, so a same-cycle MAC read sees the old value.
   generate
      for (genvar gi = 0; gi < M; gi++) begin : g_coef
         always_ff @(posedge clk) begin
            if (reset) begin
               r_coef[gi] <= '0;
            end else if (coef_we && (32'(coef_addr) == gi)) begin
               r_coef[gi] <= coef_data;
            end
         end
      end
   endgenerate

   // Sequencer: accept a sample, run M MAC cycles, then load the output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_primed    <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state <= MAC;
                  r_acc   <= '0;
                  r_idx   <= '0;
                  if (r_cnt != CW'(TAPS)) begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_acc <= w_acc_sum;
               if (w_is_centre) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_y_out;
                  if (r_cnt == CW'(TAPS)) begin
                     r_primed <= 1'b1;
                  end
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_filter_seq.sv
// tb_fir_filter_seq: directed test of fir_filter_seq at default parameters.
// Expected values are hand-computed; FIR_SAT_EN selects the clamped variants.
module tb_fir_filter_seq;

   localparam int DATA_W = 10;
   localparam int COEF_W = 16;
   localparam int TAPS   = 31;
   localparam int ACC_W  = 32;
   localparam int M      = 16;
   localparam int LIMIT  = 40;

`ifdef FIR_SAT_EN
   localparam int EXP_DC1023 = 1023;
   localparam int EXP_NEG    = 0;
`else
   localparam int EXP_DC1023 = 958;
   localparam int EXP_NEG    = 524;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready;
   logic              coef_we = 1'b0;
   logic [3:0]        coef_addr = '0;
   logic [COEF_W-1:0] coef_data = '0;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_primed;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] y;
   int                lat;
   int                rdy_hi;
   logic              primed;
   int                stray;
   int                dval;
   bit                rdy;
   int                acc_c[$];
   int                ov_c[$];
   int                ov_d[$];

   fir_filter_seq #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .TAPS   (TAPS),
      .ACC_W  (ACC_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_data  (coef_data),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_primed (out_primed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // All tasks start and end on a falling edge.
   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wr_coef(input int a, input logic [COEF_W-1:0] d);
      coef_we   = 1'b1;
      coef_addr = 4'(a);
      coef_data = d;
      @(negedge clk);
      coef_we   = 1'b0;
   endtask

   task automatic wr_all(input logic [COEF_W-1:0] d);
      for (int i = 0; i < M; i++) wr_coef(i, d);
   endtask

   // One sample in, one result out; lat counts cycles from the accept edge.
   task automatic xfer(input logic [DATA_W-1:0] d, output logic [DATA_W-1:0] yo,
                       output int lo, output int ro, output logic po);
      int n;
      n = 0;
      while (!in_ready && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
      lo = 1;
      ro = 0;
      while (!out_valid && lo < LIMIT) begin
         if (in_ready) ro++;
         @(negedge clk);
         lo++;
      end
      yo = out_data;
      po = out_primed;
      $display("xfer in=%0d out=%0d latency=%0d primed=%0d", d, yo, lo, po);
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_primed", out_primed, 0);

      // Zero coefficients: latency and ready timing
      xfer(10'd512, y, lat, rdy_hi, primed);
      chk("zero_latency", lat, 17);
      chk("zero_out", y, 0);
      chk("zero_ready_low", rdy_hi, 0);
      chk("zero_ready_back", in_ready, 1);

      // Impulse through the outermost pair
      do_reset();
      wr_coef(0, 16'h4000);
      xfer(10'd1000, y, lat, rdy_hi, primed);
      chk("imp_first", y, 500);
      for (int k = 2; k <= 32; k++) begin
         xfer(10'd0, y, lat, rdy_hi, primed);
         if (k == 31) begin
            chk("imp_31", y, 500);
            chk("imp_primed_31", primed, 1);
         end else begin
            chk("imp_zero", y, 0);
         end
         if (k == 30) chk("imp_primed_30", primed, 0);
      end

      // DC 100 through all-0x0800 coefficients
      do_reset();
      wr_all(16'h0800);
      for (int k = 1; k <= 31; k++) begin
         xfer(10'd100, y, lat, rdy_hi, primed);
         if (k == 1) chk("dc100_first", y, 6);
         if (k == 30) chk("dc100_primed_30", primed, 0);
         if (k == 31) begin
            chk("dc100_out", y, 193);
            chk("dc100_primed", primed, 1);
            chk("dc100_latency", lat, 17);
         end
      end

      // Reset in MAC cycle 8 aborts and clears everything
      in_valid = 1'b1;
      in_data  = 10'd500;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_primed", out_primed, 0);
      stray = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid) stray++;
      end
      chk("abort_stray", stray, 0);
      xfer(10'd1000, y, lat, rdy_hi, primed);
      chk("abort_coef_zero", y, 0);
      chk("abort_latency", lat, 17);

      // DC full scale
      do_reset();
      wr_all(16'h0800);
      for (int k = 1; k <= 31; k++) begin
         xfer(10'd1023, y, lat, rdy_hi, primed);
         if (k == 31) chk("dc1023_out", y, EXP_DC1023);
      end

      // Negative coefficient
      do_reset();
      wr_coef(0, 16'hC000);
      xfer(10'd1000, y, lat, rdy_hi, primed);
      chk("neg_out", y, EXP_NEG);

      // Held in_valid with an incrementing counter
      do_reset();
      wr_coef(0, 16'h7FFF);
      dval = 20;
      for (int c = 0; c < 100; c++) begin
         in_valid = 1'b1;
         in_data  = 10'(dval);
         rdy      = in_ready;
         if (out_valid) begin
            ov_c.push_back(c);
            ov_d.push_back(int'(out_data));
            $display("stream out=%0d cycle=%0d", out_data, c);
         end
         @(negedge clk);
         if (rdy) begin
            acc_c.push_back(c);
            $display("stream in=%0d cycle=%0d", dval, c);
            dval++;
         end
      end
      in_valid = 1'b0;
      chk("tp_accepts", acc_c.size(), 6);
      chk("tp_outputs", ov_c.size(), 5);
      for (int k = 0; k < ov_c.size(); k++) begin
         if (k < acc_c.size()) chk("tp_latency", ov_c[k] - acc_c[k], 17);
         chk("tp_data", ov_d[k], 19 + k);
      end
      for (int k = 1; k < acc_c.size(); k++) begin
         chk("tp_spacing", acc_c[k] - acc_c[k-1], 17);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
